// File: rtl/uart_loopback_buffer.sv
// uart_loopback_buffer: rx-to-tx character FIFO with transform modes and a tx_start/tx_busy handshake FSM
// Ports: clk/rst; mode (00 echo, 01 upper, 10 lower, 11 discard); rx_data/rx_done from the receiver;
// tx_busy/tx_start/tx_data to the transmitter; level/empty/full/almost_full status; ovf_cnt rejected pushes; tx_err sticky timeout
module uart_loopback_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_LVL    = 12,
  parameter int BUSY_TIMEOUT = 16,
  parameter int OVF_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_done,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [OVF_CNT_W-1:0]  ovf_cnt,
  output logic                  tx_err
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_L = (ADDR_WIDTH + 1)'(AFULL_LVL);
  localparam bit CASE_EN = DATA_WIDTH == 8;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_q, rd_q;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [1:0]            state_q, state_d;
  logic [TW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d, head, xf;
  logic [OVF_CNT_W-1:0]  ovf_q, ovf_d;
  logic                  empty_q, full_q, afull_q, err_q, err_d;
  logic                  pop, push, is_lo, is_up;
  assign head = mem_q[rd_q];
  assign pop = state_q == IDLE && !empty_q && !tx_busy;
  // a full FIFO still accepts a character when the head leaves on the same edge
  assign push = rx_done && (!full_q || pop);
  assign is_lo = CASE_EN && head >= DATA_WIDTH'(8'h61) && head <= DATA_WIDTH'(8'h7a);
  assign is_up = CASE_EN && head >= DATA_WIDTH'(8'h41) && head <= DATA_WIDTH'(8'h5a);
  assign xf = (mode == 2'b01 && is_lo) ? head - DATA_WIDTH'(8'h20) :
              (mode == 2'b10 && is_up) ? head + DATA_WIDTH'(8'h20) : head;
  assign level_d = level_q + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(pop);
  assign ovf_d = (rx_done && !push && ovf_q != '1) ? ovf_q + OVF_CNT_W'(1) : ovf_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    err_d = err_q;
    tx_data_d = tx_data_q;
    case (state_q)
      IDLE: if (pop && mode != 2'b11) begin
        tx_data_d = xf;
        state_d = START;
      end
      START: begin
        cnt_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
        else if (cnt_q == TW'(BUSY_TIMEOUT - 1)) begin
          err_d = 1'b1;
          state_d = IDLE;
        end else cnt_d = cnt_q + 1'b1;
      default: state_d = tx_busy ? WAIT_DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= rx_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      tx_data_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
      afull_q <= 1'b0;
      ovf_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tx_data_q <= tx_data_d;
      wr_q <= push ? wr_q + 1'b1 : wr_q;
      rd_q <= pop ? rd_q + 1'b1 : rd_q;
      level_q <= level_d;
      empty_q <= level_d == '0;
      full_q <= level_d == DEPTH_L;
      afull_q <= level_d >= AFULL_L;
      ovf_q <= ovf_d;
      err_q <= err_d;
    end
  end
  assign tx_start = state_q == START;
  assign tx_data = tx_data_q;
  assign level = level_q;
  assign empty = empty_q;
  assign full = full_q;
  assign almost_full = afull_q;
  assign ovf_cnt = ovf_q;
  assign tx_err = err_q;
endmodule

// File: tb/tb_uart_loopback_buffer.sv
// tb_uart_loopback_buffer: directed and randomized checks of uart_loopback_buffer against a queue-based model
module tb_uart_loopback_buffer;
  localparam int BT = 16;
  logic clk = 1'b0;
  logic rst, rx_done, tx_busy, tx_start, empty, full, almost_full, tx_err;
  logic [1:0] mode;
  logic [7:0] rx_data, tx_data, ovf_cnt;
  logic [4:0] level;
  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q [$];
  logic [7:0] tmp;
  int rsp_wait = 0;
  int rsp_len = 0;
  int pushes = 0;
  logic prev_start = 1'b0;

  uart_loopback_buffer dut (
    .clk(clk), .rst(rst), .mode(mode), .rx_data(rx_data), .rx_done(rx_done),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .level(level),
    .empty(empty), .full(full), .almost_full(almost_full), .ovf_cnt(ovf_cnt), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    rx_data = c;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  function automatic logic [7:0] model_xf(input logic [1:0] m, input logic [7:0] c);
    if (m == 2'b01 && c >= 8'h61 && c <= 8'h7a) return c - 8'h20;
    if (m == 2'b10 && c >= 8'h41 && c <= 8'h5a) return c + 8'h20;
    return c;
  endfunction

  task automatic serve(input string tag, input logic [7:0] exp);
    tx_busy = 1'b0;
    for (int i = 0; i < 64 && !tx_start; i++) tick();
    chk({tag, "_start"}, tx_start, 1);
    chk({tag, "_data"}, tx_data, exp);
    tx_busy = 1'b1;
    tick();
    chk({tag, "_pulse"}, tx_start, 0);
    tick();
    tick();
    tx_busy = 1'b0;
    tick();
  endtask

  task automatic rnd_step(input bit allow_push);
    rx_done = 1'b0;
    if (allow_push && pushes < 14 && exp_q.size() < 13 && $urandom_range(0, 1) == 1) begin
      rx_data = $urandom_range(0, 1) == 1 ? 8'($urandom_range(8'h3f, 8'h7c)) : 8'($urandom);
      rx_done = 1'b1;
      pushes++;
      if (mode != 2'b11) exp_q.push_back(rx_data);
    end
    tick();
    rx_done = 1'b0;
    if (prev_start) chk("rnd_pulse", tx_start, 0);
    if (mode == 2'b11) chk("rnd_discard_nostart", tx_start, 0);
    else if (tx_start) begin
      chk("rnd_sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        tmp = exp_q.pop_front();
        chk("rnd_data", tx_data, model_xf(mode, tmp));
      end
    end
    prev_start = tx_start;
    if (tx_start) begin
      rsp_wait = $urandom_range(0, 2);
      rsp_len = $urandom_range(2, 4);
    end
    if (rsp_wait > 0) begin
      tx_busy = 1'b0;
      rsp_wait--;
    end else if (rsp_len > 0) begin
      tx_busy = 1'b1;
      rsp_len--;
    end else tx_busy = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rx_done = 1'b0;
    rx_data = '0;
    tx_busy = 1'b0;
    mode = 2'b00;
    tick();
    tick();
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_ovf", ovf_cnt, 0);
    chk("rst_err", tx_err, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_start", tx_start, 0);

    send(8'h41);
    chk("single_nostart_n", tx_start, 0);
    chk("single_level_n", level, 1);
    tick();
    chk("single_start", tx_start, 1);
    chk("single_data", tx_data, 8'h41);
    chk("single_level_pop", level, 0);
    chk("single_empty_pop", empty, 1);
    tx_busy = 1'b1;
    tick();
    chk("single_pulse", tx_start, 0);
    tick();
    tick();
    tx_busy = 1'b0;
    tick();
    tick();
    chk("single_done_start", tx_start, 0);
    chk("single_done_level", level, 0);

    mode = 2'b01;
    tx_busy = 1'b1;
    send(8'h61);
    send(8'h7a);
    send(8'h31);
    serve("upper_61", 8'h41);
    serve("upper_7a", 8'h5a);
    serve("upper_31", 8'h31);
    mode = 2'b10;
    tx_busy = 1'b1;
    send(8'h41);
    send(8'h5b);
    serve("lower_41", 8'h61);
    serve("lower_5b", 8'h5b);
    mode = 2'b00;

    tx_busy = 1'b1;
    exp_q.delete();
    for (int i = 1; i <= 20; i++) begin
      tmp = 8'($urandom);
      if (i <= 16) exp_q.push_back(tmp);
      send(tmp);
      if (i == 11) chk("ovf_afull_11", almost_full, 0);
      if (i == 12) chk("ovf_afull_12", almost_full, 1);
      if (i == 15) chk("ovf_full_15", full, 0);
    end
    chk("ovf_level", level, 16);
    chk("ovf_full", full, 1);
    chk("ovf_afull", almost_full, 1);
    chk("ovf_cnt", ovf_cnt, 4);
    for (int i = 0; i < 16; i++) serve("ovf_drain", exp_q.pop_front());
    chk("ovf_drained", empty, 1);

    tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tmp = 8'($urandom);
      exp_q.push_back(tmp);
      send(tmp);
    end
    chk("pp_full_before", full, 1);
    tmp = 8'($urandom);
    exp_q.push_back(tmp);
    rx_data = tmp;
    rx_done = 1'b1;
    tx_busy = 1'b0;
    tick();
    rx_done = 1'b0;
    chk("pp_level", level, 16);
    chk("pp_full", full, 1);
    chk("pp_ovf", ovf_cnt, 4);
    chk("pp_start", tx_start, 1);
    for (int i = 0; i < 17; i++) serve("pp_drain", exp_q.pop_front());
    chk("pp_drained", level, 0);

    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) send(8'($urandom));
    chk("disc_level5", level, 5);
    mode = 2'b11;
    tx_busy = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("disc_level", level, 32'(5 - k));
      chk("disc_nostart", tx_start, 0);
    end
    chk("disc_empty", empty, 1);
    tick();
    chk("disc_nostart_after", tx_start, 0);
    mode = 2'b00;

    send(8'h55);
    for (int i = 0; i < 64 && !tx_start; i++) tick();
    chk("to_start", tx_start, 1);
    chk("to_data", tx_data, 8'h55);
    for (int t = 1; t <= BT + 2; t++) begin
      tick();
      if (t == BT / 2) chk("to_err_early", tx_err, 0);
    end
    chk("to_err", tx_err, 1);
    send(8'h66);
    serve("to_recover", 8'h66);
    chk("to_err_sticky", tx_err, 1);

    send(8'h21);
    for (int i = 0; i < 64 && !tx_start; i++) tick();
    chk("rm_start", tx_start, 1);
    tx_busy = 1'b1;
    send(8'h22);
    tick();
    chk("rm_level", level, 1);
    rst = 1'b1;
    tick();
    chk("rm_tx_start", tx_start, 0);
    chk("rm_tx_data", tx_data, 0);
    chk("rm_level0", level, 0);
    chk("rm_empty", empty, 1);
    chk("rm_full", full, 0);
    chk("rm_afull", almost_full, 0);
    chk("rm_ovf", ovf_cnt, 0);
    chk("rm_err", tx_err, 0);
    rst = 1'b0;
    tx_busy = 1'b0;
    tick();
    chk("rm_post_start", tx_start, 0);
    chk("rm_post_level", level, 0);

    exp_q.delete();
    prev_start = 1'b0;
    for (int b = 0; b < 10; b++) begin
      mode = 2'($urandom_range(0, 3));
      pushes = 0;
      for (int c = 0; c < 50; c++) rnd_step(1'b1);
      for (int i = 0; i < 400 && (exp_q.size() != 0 || rsp_len != 0 || rsp_wait != 0 || tx_busy || level != 0); i++)
        rnd_step(1'b0);
      rnd_step(1'b0);
      rnd_step(1'b0);
      chk("rnd_sb_drained", exp_q.size(), 0);
      chk("rnd_level", level, 0);
      chk("rnd_empty", empty, 1);
    end
    chk("rnd_ovf", ovf_cnt, 0);
    chk("rnd_err", tx_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
